// File: rtl/t481_pkg.sv
// t481_pkg: shared widths, defaults and the S1 stage record for the t481
// arbiter slice.
//   NREQ_DEFAULT : default number of requesters
//   ID_W         : requester index width
//   VEC_W        : evaluator operand width (v0..v15)
//   CNT_W        : completed-response counter width
//   s1_t         : S1 payload {vec, id}
package t481_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned ID_W         = 2;
    localparam int unsigned VEC_W        = 16;
    localparam int unsigned CNT_W        = 16;

    typedef struct packed {
        logic [VEC_W-1:0] vec;
        logic [ID_W-1:0]  id;
    } s1_t;

endpackage

// File: rtl/t481.sv
// t481: combinational evaluator producing v160 from inputs v0..v15.
// v160 is the even-parity flag of v0..v15: 1 when an even number of the
// inputs are set.
// Ports:
//   v    : input,  VEC_W bits, bit k is evaluator input vk
//   v160 : output, 1 bit, evaluator result
module t481
    import t481_pkg::*;
(
    input  logic [VEC_W-1:0] v,
    output logic             v160
);

    assign v160 = ~(^v);

endmodule

// File: rtl/t481_arb.sv
// t481_arb: round-robin arbiter feeding one shared t481 evaluator through a
// two-stage pipeline (S1 = captured operand + id, S2 = result + id).
// Ports:
//   clk       : input,  rising-edge clock
//   rst       : input,  synchronous active-high reset
//   req       : input,  NREQ bits, per-requester request level
//   vec       : input,  NREQ x VEC_W, per-requester operand
//   ack       : output, NREQ bits, one-hot accept strobe (combinational)
//   rsp_valid : output, result presented
//   rsp_ready : input,  downstream accepts the result
//   rsp_id    : output, ID_W bits, originating requester
//   rsp_data  : output, evaluator v160 for the captured operand
//   done_cnt  : output, CNT_W bits, completed response count (wraps)
module t481_arb
    import t481_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][VEC_W-1:0] vec,
    output logic [NREQ-1:0]            ack,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       rsp_data,
    output logic [CNT_W-1:0]           done_cnt
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win;
    logic             any_req;
    logic             grant;
    logic             stall;
    logic             s1_free;
    logic             s1_adv;
    logic             s1_valid_q;
    s1_t              s1_q;
    logic             v160;

    assign stall   = rsp_valid & ~rsp_ready;
    assign s1_free = ~s1_valid_q | ~stall;
    assign s1_adv  = s1_valid_q & ~stall;
    assign grant   = any_req & s1_free & ~rst;

    // Scan requesters starting at ptr; the first active one wins.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        win     = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!any_req && req[idx[PTR_W-1:0]]) begin
                any_req = 1'b1;
                win     = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ack   = '0;
        ptr_d = ptr_q;
        if (grant) begin
            ack[win] = 1'b1;
            ptr_d    = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end
    end

    t481 u_eval (
        .v    (s1_q.vec),
        .v160 (v160)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= 1'b0;
            done_cnt   <= '0;
        end else begin
            ptr_q <= ptr_d;

            // S1 reload wins over clearing so back-to-back grants have no bubble.
            if (grant) begin
                s1_q.vec   <= vec[win];
                s1_q.id    <= ID_W'(win);
                s1_valid_q <= 1'b1;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                rsp_valid <= 1'b1;
                rsp_id    <= s1_q.id;
                rsp_data  <= v160;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            if (rsp_valid && rsp_ready) begin
                done_cnt <= done_cnt + 1'b1;
            end
        end
    end

endmodule
